// File: rtl/crc16_frame_gen.sv
// crc16_frame_gen: pulls FRAME_LEN payload bytes from a non-showahead byte FIFO,
// forwards each byte on a valid/ready stream, and runs CRC-16-CCITT over them
// (poly 0x1021, MSB-first, no reflection, no final XOR). The two CRC bytes are
// appended MSB first, and o_out_last marks the final CRC byte.
// Optional build macro: CRC16_FRAME_CNT_EN adds o_frame_cnt, a saturating count of done pulses.
module crc16_frame_gen #(
  parameter int          FRAME_LEN = 512,
  parameter int          LEN_W     = 10,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_fifo_empty,
  input  logic [7:0]  i_fifo_q,
  output logic        o_fifo_rdreq,
  output logic [7:0]  o_out_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_out_last,
  output logic [15:0] o_crc_out,
  output logic        o_busy,
`ifdef CRC16_FRAME_CNT_EN
  output logic [15:0] o_frame_cnt,
`endif
  output logic        o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_CRC_HI,
    S_CRC_LO
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [LEN_W-1:0] r_count;
  logic [15:0]      r_crc;
  logic [7:0]       r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_done;
  logic             w_fifo_rdreq;
  logic             w_last_byte;

  // One full byte of the CRC-16-CCITT shift register, eight bit-steps unrolled.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data_in);
    logic [15:0] c;
    logic        fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data_in[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  assign w_last_byte = (r_count == LEN_W'(FRAME_LEN - 1));

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, plus the combinational FIFO pop (only in FETCH, only when data exists).
  always_comb begin
    w_next_state = r_state;
    w_fifo_rdreq = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!i_fifo_empty) begin
          w_fifo_rdreq = 1'b1;
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        w_next_state = S_SEND;
      end
      S_SEND: begin
        if (i_out_ready) begin
          w_next_state = w_last_byte ? S_CRC_HI : S_FETCH;
        end
      end
      S_CRC_HI: begin
        if (i_out_ready) begin
          w_next_state = S_CRC_LO;
        end
      end
      S_CRC_LO: begin
        if (i_out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: counter, CRC and registered stream outputs; nothing moves while a beat is stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count     <= '0;
      r_crc       <= CRC_INIT;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_crc   <= CRC_INIT;
            r_count <= '0;
          end
        end
        S_LOAD: begin
          r_out_data  <= i_fifo_q;
          r_crc       <= crc16_byte(r_crc, i_fifo_q);
          r_out_valid <= 1'b1;
        end
        S_SEND: begin
          if (i_out_ready) begin
            if (w_last_byte) begin
              r_out_data <= r_crc[15:8];
            end else begin
              r_out_valid <= 1'b0;
              r_count     <= r_count + LEN_W'(1);
            end
          end
        end
        S_CRC_HI: begin
          if (i_out_ready) begin
            r_out_data <= r_crc[7:0];
            r_out_last <= 1'b1;
          end
        end
        S_CRC_LO: begin
          if (i_out_ready) begin
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef CRC16_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;

  // Completed-frame counter, sticks at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_frame_cnt <= 16'h0000;
    end else if (r_done && (r_frame_cnt != 16'hFFFF)) begin
      r_frame_cnt <= r_frame_cnt + 16'h0001;
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`endif

  assign o_fifo_rdreq = w_fifo_rdreq;
  assign o_out_data   = r_out_data;
  assign o_out_valid  = r_out_valid;
  assign o_out_last   = r_out_last;
  assign o_crc_out    = r_crc;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done       = r_done;

endmodule
